vga_timing_controller: RTL and testbench
========================================

// Module: vga_timing_controller
// PURPOSE
//  Sequences the VGA pixel datapath: derives a pixel-rate enable from the system clock and
//  generates horizontal/vertical timing (sync, blanking, pixel coordinates, line/frame
//  markers) for 640x480@60. Sits between the board clock and the pixel/colour generator.
// PARAMETERS
//  CLK_DIV   2    system clocks per pixel (>=1); 2 gives 25 MHz from 50 MHz
//  H_ACTIVE  640  visible pixels per line
//  H_FRONT   16   horizontal front porch, pixels
//  H_SYNC    96   horizontal sync width, pixels
//  H_BACK    48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FRONT   10   vertical front porch, lines
//  V_SYNC    2    vertical sync width, lines
//  V_BACK    33   vertical back porch, lines
//  SYNC_POL  0    sync active level (0 = active-low)
// PORTS
//  clock        in   1   system clock, all logic on posedge
//  reset_n      in   1   asynchronous, active-low reset
//  enable       in   1   1 = run; 0 = freeze divider and counters
//  pixel_tick   out  1   one-clock pulse per pixel period
//  hsync        out  1   horizontal sync, level per SYNC_POL
//  vsync        out  1   vertical sync, level per SYNC_POL
//  video_on     out  1   1 while h and v both in active region
//  pixel_x      out  10  current column when video_on, else 0
//  pixel_y      out  10  current row when video_on, else 0
//  line_start   out  1   1-clock pulse: pixel_tick && h_cnt==0
//  frame_start  out  1   1-clock pulse: pixel_tick && h_cnt==0 && v_cnt==0
// BEHAVIOUR
//  - H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Counter widths $clog2(TOTAL).
//  - Reset: div_cnt=0, h_cnt=0, v_cnt=0, both phase FSMs in ACT. Outputs: pixel_tick=0,
//    line_start=0, frame_start=0, hsync=vsync=~SYNC_POL, video_on=1, pixel_x=pixel_y=0.
//  - Divider: div_cnt counts 0..CLK_DIV-1 while enable=1, wraps to 0. pixel_tick=1 when
//    div_cnt==CLK_DIV-1 && enable. First tick occurs in the CLK_DIV-th enabled clock after
//    reset release. CLK_DIV=1: pixel_tick==enable.
//  - pixel_tick means the current (h_cnt,v_cnt) pixel is consumed; counters advance on it.
//  - h_cnt increments on pixel_tick; at H_TOTAL-1 wraps to 0 and v_cnt increments;
//    v_cnt at V_TOTAL-1 with h wrap wraps to 0. Both wrap in the same clock at frame end.
//  - H phase FSM ACT->FP->SYNC->BP->ACT, transitions on pixel_tick at boundaries
//    h_cnt=H_ACTIVE-1, +H_FRONT, +H_SYNC, H_TOTAL-1. V FSM identical, advances on h wrap.
//    FSM state must always equal the region decoded from the counter (checked by assertion).
//  - hsync = SYNC_POL while H phase==SYNC (h_cnt 656..751); vsync likewise (v_cnt 490..491).
//  - video_on = (H==ACT)&&(V==ACT). Outputs decoded from registered state, zero added
//    latency versus counters; no combinational path from enable except pixel_tick/markers.
//  - enable=0: div_cnt, counters, FSMs hold; pixel_tick/line_start/frame_start=0; level
//    outputs hold. Re-enable resumes the divider from the held div_cnt.
//  - reset_n asserted mid-frame: immediate return to reset values, next frame starts at (0,0).
// STRUCTURE
//  - Package vga_timing_pkg: default 640x480 timing localparams, typedef enum
//    phase_t {PH_ACT, PH_FP, PH_SYNC, PH_BP}, function phase_of(cnt, act, fp, sync).
//  - One sub-module pixel_tick_gen (CLK_DIV): clock, reset_n, enable -> tick.
//  - Top holds h/v counters, both phase FSMs and output decode.
// TESTING
//  1 Reset: hold reset_n=0 10 clocks -> hsync=vsync=1, video_on=1, pixel_x=y=0, no ticks.
//  2 Release, enable=1, CLK_DIV=2 -> first pixel_tick at clock 2, then every 2 clocks;
//    frame_start on first tick; line_start every 1600 clocks.
//  3 Line timing -> hsync low exactly 96 ticks starting h_cnt=656; video_on low at 640..799.
//  4 Frame timing -> vsync low 2 lines (v 490-491); frame_start period 840000 clocks;
//    pixel_x=639,pixel_y=479 seen once per frame then both 0 outside active area.
//  5 enable=0 for 37 clocks at h_cnt=300 -> all counters/levels hold, no pulses; resumes
//    at h_cnt=300 with unchanged div phase.
//  6 reset_n pulse at (h=700,v=200); rerun with CLK_DIV=1 -> restart at (0,0); tick every clock.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing controller.
// Default 640x480@60 timing constants, the phase type used by both the
// horizontal and vertical phase FSMs, and a helper that decodes the phase
// implied by a raw counter value.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_t;

  // Region a counter value falls in; anything past the sync window is back porch.
  function automatic phase_t phase_of(input int cnt, input int act, input int fp,
                                      input int sync);
    if (cnt < act)             return PH_ACT;
    if (cnt < act + fp)        return PH_FP;
    if (cnt < act + fp + sync) return PH_SYNC;
    return PH_BP;
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable generator.
// Divides the system clock by CLK_DIV, producing a one-clock tick per pixel.
// Ports:
//   clock    in  system clock
//   reset_n  in  asynchronous active-low reset
//   enable   in  1 = count, 0 = hold the divider phase
//   tick     out one-clock pulse when the divider is in its last phase
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (enable) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value, independent of statement order.
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + DW'(1);
    end
  end

  // With CLK_DIV=1 the divider is always in its last phase, so the tick would
  // follow enable even while held in reset; reset_n keeps it quiet then.
  assign tick = enable && reset_n && (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_controller.sv
// VGA timing controller.
// Generates horizontal/vertical sync, blanking, pixel coordinates and
// line/frame markers from a divided pixel-rate tick.
// Ports:
//   clock        in  system clock
//   reset_n      in  asynchronous active-low reset
//   enable       in  1 = run, 0 = freeze divider, counters and phases
//   pixel_tick   out one-clock pulse per pixel period
//   hsync/vsync  out sync levels, active at SYNC_POL
//   video_on     out both axes in the active region
//   pixel_x/y    out current column/row while video_on, else 0
//   line_start   out tick on the first pixel of a line
//   frame_start  out tick on the first pixel of a frame
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  // Last count of each region; the phase FSM leaves the region on a tick here.
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_FP_END   = HW'(H_ACTIVE + H_FRONT - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_FP_END   = VW'(V_ACTIVE + V_FRONT - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  phase_t        h_ph;
  phase_t        v_ph;
  logic          h_wrap;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (pixel_tick)
  );

  assign h_wrap = pixel_tick && (h_cnt == H_LAST);

  // Horizontal counter and phase FSM share one register block so they can
  // never disagree about which tick moved them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      h_ph  <= PH_ACT;
    end else if (pixel_tick) begin
      h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + HW'(1);
      case (h_ph)
        PH_ACT:  if (h_cnt == H_ACT_END)  h_ph <= PH_FP;
        PH_FP:   if (h_cnt == H_FP_END)   h_ph <= PH_SYNC;
        PH_SYNC: if (h_cnt == H_SYNC_END) h_ph <= PH_BP;
        PH_BP:   if (h_cnt == H_LAST)     h_ph <= PH_ACT;
        default:                          h_ph <= PH_ACT;
      endcase
    end
  end

  // Vertical axis advances only when the horizontal counter wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_cnt <= '0;
      v_ph  <= PH_ACT;
    end else if (h_wrap) begin
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      case (v_ph)
        PH_ACT:  if (v_cnt == V_ACT_END)  v_ph <= PH_FP;
        PH_FP:   if (v_cnt == V_FP_END)   v_ph <= PH_SYNC;
        PH_SYNC: if (v_cnt == V_SYNC_END) v_ph <= PH_BP;
        PH_BP:   if (v_cnt == V_LAST)     v_ph <= PH_ACT;
        default:                          v_ph <= PH_ACT;
      endcase
    end
  end

  // Level outputs decode registered state only, so they move in the same
  // clock as the counters and never depend on enable.
  assign hsync       = (h_ph == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign vsync       = (v_ph == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign video_on    = (h_ph == PH_ACT) && (v_ph == PH_ACT);
  assign pixel_x     = video_on ? 10'(h_cnt) : 10'd0;
  assign pixel_y     = video_on ? 10'(v_cnt) : 10'd0;
  assign line_start  = pixel_tick && (h_cnt == '0);
  assign frame_start = line_start && (v_cnt == '0);

  // The FSMs duplicate information held in the counters; they must agree.
  a_h_phase: assert property (@(posedge clock) disable iff (!reset_n)
    h_ph == phase_of(int'(h_cnt), H_ACTIVE, H_FRONT, H_SYNC));
  a_v_phase: assert property (@(posedge clock) disable iff (!reset_n)
    v_ph == phase_of(int'(v_cnt), V_ACTIVE, V_FRONT, V_SYNC));

endmodule

// File: tb/tb_vga_timing_controller.sv
// Self-checking bench for vga_timing_controller.
// Three instances share clock, reset and enable: full 640x480 timing at
// CLK_DIV=2, and a reduced 15x9 geometry at CLK_DIV=2 and CLK_DIV=1.
// A behavioural model predicts every output each clock; predictions go to a
// scoreboard queue and are compared against the instances' outputs.
module tb_vga_timing_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n = 1'b0;
  logic enable  = 1'b1;

  logic       tick_w[3], hs_w[3], vs_w[3], von_w[3], ls_w[3], fs_w[3];
  logic [9:0] px_w[3], py_w[3];

  vga_timing_controller #(.CLK_DIV(2)) dut_f (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .pixel_tick(tick_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]), .video_on(von_w[0]),
    .pixel_x(px_w[0]), .pixel_y(py_w[0]), .line_start(ls_w[0]), .frame_start(fs_w[0])
  );

  vga_timing_controller #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b0)
  ) dut_s2 (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .pixel_tick(tick_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]), .video_on(von_w[1]),
    .pixel_x(px_w[1]), .pixel_y(py_w[1]), .line_start(ls_w[1]), .frame_start(fs_w[1])
  );

  vga_timing_controller #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b0)
  ) dut_s1 (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .pixel_tick(tick_w[2]), .hsync(hs_w[2]), .vsync(vs_w[2]), .video_on(von_w[2]),
    .pixel_x(px_w[2]), .pixel_y(py_w[2]), .line_start(ls_w[2]), .frame_start(fs_w[2])
  );

  typedef struct packed {
    logic       tick, ls, fs, hs, vs, von;
    logic [9:0] x, y;
  } out_t;

  typedef struct {
    int   inst;
    out_t o;
  } sb_t;

  typedef struct {
    bit rst_n;
    bit en;
    int n;
    bit first_tick;
    int ticks;
    int lines;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Model geometry per instance.
  int p_cd[3] = '{2, 2, 1};
  int p_ha[3] = '{640, 8, 8};
  int p_hf[3] = '{16, 2, 2};
  int p_hs[3] = '{96, 3, 3};
  int p_hb[3] = '{48, 2, 2};
  int p_va[3] = '{480, 4, 4};
  int p_vf[3] = '{10, 1, 1};
  int p_vs[3] = '{2, 2, 2};
  int p_vb[3] = '{33, 2, 2};

  int   m_div[3], m_h[3], m_v[3];
  out_t cur[3];
  sb_t  sbq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic out_t model_out(input int i);
    out_t o;
    int hs_lo, vs_lo;
    hs_lo  = p_ha[i] + p_hf[i];
    vs_lo  = p_va[i] + p_vf[i];
    o.tick = enable && reset_n && (m_div[i] == p_cd[i] - 1);
    o.hs   = !(m_h[i] >= hs_lo && m_h[i] < hs_lo + p_hs[i]);
    o.vs   = !(m_v[i] >= vs_lo && m_v[i] < vs_lo + p_vs[i]);
    o.von  = (m_h[i] < p_ha[i]) && (m_v[i] < p_va[i]);
    o.x    = o.von ? 10'(m_h[i]) : 10'd0;
    o.y    = o.von ? 10'(m_v[i]) : 10'd0;
    o.ls   = o.tick && (m_h[i] == 0);
    o.fs   = o.ls && (m_v[i] == 0);
    return o;
  endfunction

  function automatic out_t dut_out(input int i);
    out_t o;
    o.tick = tick_w[i];
    o.ls   = ls_w[i];
    o.fs   = fs_w[i];
    o.hs   = hs_w[i];
    o.vs   = vs_w[i];
    o.von  = von_w[i];
    o.x    = px_w[i];
    o.y    = py_w[i];
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_div[i] = 0;
      m_h[i]   = 0;
      m_v[i]   = 0;
    end
  endtask

  task automatic model_advance();
    int ht, vt;
    for (int i = 0; i < 3; i++) begin
      ht = p_ha[i] + p_hf[i] + p_hs[i] + p_hb[i];
      vt = p_va[i] + p_vf[i] + p_vs[i] + p_vb[i];
      if (!reset_n) begin
        m_div[i] = 0; m_h[i] = 0; m_v[i] = 0;
      end else if (enable) begin
        if (m_div[i] == p_cd[i] - 1) begin
          m_div[i] = 0;
          if (m_h[i] == ht - 1) begin
            m_h[i] = 0;
            m_v[i] = (m_v[i] == vt - 1) ? 0 : m_v[i] + 1;
          end else begin
            m_h[i] = m_h[i] + 1;
          end
        end else begin
          m_div[i] = m_div[i] + 1;
        end
      end
    end
  endtask

  // One clock: called at a falling edge with inputs already set.
  task automatic step();
    sb_t  e;
    out_t a;
    #1;
    if (!reset_n) model_reset();
    for (int i = 0; i < 3; i++) begin
      e.inst = i;
      e.o    = model_out(i);
      sbq.push_back(e);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = dut_out(e.inst);
      cur[e.inst] = a;
      checks++;
      if (a !== e.o) begin
        errors++;
        $display("FAIL sb_inst%0d @%0t got %h expected %h", e.inst, $time, a, e.o);
      end
    end
    @(posedge clock);
    model_advance();
    @(negedge clock);
  endtask

  task automatic measure_frame(input int i, input int exp_n, input int exp_lines,
                               input int exp_vlo);
    int n, lines, corner, vlo;
    n = 0;
    while (cur[i].fs !== 1'b1 && n < 600) begin
      step();
      n++;
    end
    check($sformatf("frame_wait_inst%0d", i), int'(cur[i].fs === 1'b1), 1);
    n = 0; lines = 1; corner = 0; vlo = 0;
    do begin
      step();
      n++;
      if (cur[i].fs !== 1'b1) begin
        lines  += int'(cur[i].ls === 1'b1);
        vlo    += int'(cur[i].vs === 1'b0);
        corner += int'(cur[i].tick === 1'b1 && cur[i].von === 1'b1 &&
                       cur[i].x == 10'd7 && cur[i].y == 10'd3);
      end
    end while (cur[i].fs !== 1'b1 && n < 1000);
    check($sformatf("frame_period_inst%0d", i), n, exp_n);
    check($sformatf("frame_lines_inst%0d", i), lines, exp_lines);
    check($sformatf("frame_last_pixel_inst%0d", i), corner, 1);
    check($sformatf("frame_vsync_low_inst%0d", i), vlo, exp_vlo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   ticks, lines, n, lo, tl;

    // Counts refer to the full-size instance; cycle 1 is the first after release.
    vt[0] = '{rst_n: 1'b0, en: 1'b1, n: 10,   first_tick: 1'b0, ticks: 0,   lines: 0};
    vt[1] = '{rst_n: 1'b1, en: 1'b1, n: 601,  first_tick: 1'b0, ticks: 300, lines: 1};
    vt[2] = '{rst_n: 1'b1, en: 1'b0, n: 37,   first_tick: 1'b0, ticks: 0,   lines: 0};
    vt[3] = '{rst_n: 1'b1, en: 1'b1, n: 799,  first_tick: 1'b1, ticks: 400, lines: 0};
    vt[4] = '{rst_n: 1'b0, en: 1'b1, n: 3,    first_tick: 1'b0, ticks: 0,   lines: 0};
    vt[5] = '{rst_n: 1'b1, en: 1'b1, n: 1700, first_tick: 1'b0, ticks: 850, lines: 2};

    model_reset();
    @(negedge clock);

    for (int k = 0; k < 6; k++) begin
      reset_n = vt[k].rst_n;
      enable  = vt[k].en;
      ticks = 0;
      lines = 0;
      for (int j = 0; j < vt[k].n; j++) begin
        step();
        if (j == 0)
          check($sformatf("seg%0d_first_tick", k), int'(cur[0].tick), int'(vt[k].first_tick));
        ticks += int'(cur[0].tick === 1'b1);
        lines += int'(cur[0].ls === 1'b1);
      end
      check($sformatf("seg%0d_ticks", k), ticks, vt[k].ticks);
      check($sformatf("seg%0d_lines", k), lines, vt[k].lines);
      if (k == 0) begin
        check("reset_hsync", int'(cur[0].hs), 1);
        check("reset_vsync", int'(cur[0].vs), 1);
        check("reset_video_on", int'(cur[0].von), 1);
        check("reset_pixel_x", int'(cur[0].x), 0);
        check("reset_pixel_y", int'(cur[0].y), 0);
      end
      if (k == 2) check("freeze_pixel_x", int'(cur[0].x), 300);
    end

    // Horizontal sync window on full-size timing.
    n = 0;
    do begin step(); n++; end while (cur[0].ls !== 1'b1 && n < 2000);
    check("hwin_line_start_seen", int'(cur[0].ls === 1'b1), 1);
    n = 0;
    do begin step(); n++; end while (cur[0].hs !== 1'b0 && n < 2000);
    check("hsync_fall_delay", n, 1311);
    lo = 0; tl = 0; n = 0;
    while (cur[0].hs === 1'b0 && n < 1000) begin
      lo++;
      tl += int'(cur[0].tick === 1'b1);
      step();
      n++;
    end
    check("hsync_low_clocks", lo, 192);
    check("hsync_low_ticks", tl, 96);
    check("video_off_back_porch", int'(cur[0].von), 0);

    // Frame timing on the reduced geometry.
    measure_frame(1, 270, 9, 60);
    measure_frame(2, 135, 9, 30);

    // Mid-frame reset, then restart at (0,0).
    for (int j = 0; j < 50; j++) step();
    reset_n = 1'b0;
    step();
    check("midreset_tick_div1", int'(cur[2].tick), 0);
    check("midreset_video_on", int'(cur[1].von), 1);
    step();
    reset_n = 1'b1;
    step();
    check("restart_frame_div1", int'(cur[2].fs), 1);
    check("restart_tick_div2_cycle1", int'(cur[1].tick), 0);
    step();
    check("restart_frame_div2", int'(cur[1].fs), 1);
    check("restart_frame_full", int'(cur[0].fs), 1);
    ticks = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      ticks += int'(cur[2].tick === 1'b1);
    end
    check("div1_tick_every_clock", ticks, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
